// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in, serial-out word serializer with a valid/ready
// load handshake and first/last-bit framing strobes.
//
// Parameters
//   N          word width in bits (N >= 2)
//   LSB_FIRST  1: bit 0 leaves first, 0: bit N-1 leaves first
//   GAP        idle serial cycles forced between consecutive words (0..255)
// Ports
//   clk          sole clock, rising edge
//   rst_n        synchronous active-low reset
//   load_data    word to serialize, sampled on handshake only
//   load_valid   upstream offers a word
//   load_ready   block can accept a word this cycle (combinational)
//   sout         serial data bit (0 when no word bit is on the line)
//   sout_valid   sout carries a word bit
//   frame_start  first bit of a word
//   frame_end    last bit of a word
//   busy         word in flight or gap pending
module piso_serializer #(
  parameter int unsigned N         = 8,
  parameter bit          LSB_FIRST = 1'b1,
  parameter int unsigned GAP       = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] load_data,
  input  logic         load_valid,
  output logic         load_ready,
  output logic         sout,
  output logic         sout_valid,
  output logic         frame_start,
  output logic         frame_end,
  output logic         busy
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned GW = 8;

  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  // Unused when GAP == 0; kept at 0 so the constant stays in range.
  localparam logic [GW-1:0] GAP_LAST = (GAP > 0) ? GW'(GAP - 1) : '0;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  shreg_q, shreg_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [GW-1:0] gcnt_q,  gcnt_d;

  logic last_bit;
  logic gap_done;
  logic accept;

  assign last_bit = (state_q == S_SHIFT) && (cnt_q == CNT_LAST);
  assign gap_done = (state_q == S_GAP) && (gcnt_q == GAP_LAST);

  // Ready on the last bit lets GAP == 0 streams run without a bubble.
  assign load_ready = rst_n && ((state_q == S_IDLE) ||
                                (last_bit && (GAP == 0)) ||
                                gap_done);
  assign accept     = load_valid && load_ready;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
    end
  end

  // Next-state logic; an accepted word overrides whatever the state would do.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;

    case (state_q)
      S_IDLE: begin
      end
      S_SHIFT: begin
        shreg_d = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
        cnt_d   = cnt_q + CW'(1);
        if (last_bit) begin
          if (GAP > 0) begin
            state_d = S_GAP;
            gcnt_d  = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_GAP: begin
        gcnt_d = gcnt_q + GW'(1);
        if (gap_done) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (accept) begin
      shreg_d = load_data;
      cnt_d   = '0;
      state_d = S_SHIFT;
    end
  end

  // Output decode from registered state.
  always_comb begin
    sout_valid  = (state_q == S_SHIFT);
    sout        = sout_valid && (LSB_FIRST ? shreg_q[0] : shreg_q[N-1]);
    frame_start = sout_valid && (cnt_q == '0);
    frame_end   = last_bit;
    busy        = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;

  // Three instances: LSB-first/GAP0, MSB-first/GAP0, LSB-first/GAP3.
  logic       clk;
  logic       rst_n;
  logic [7:0] ld [3];
  logic       lv [3];
  logic [2:0] lr, so, sv, fs, fe, bz;
  logic       mon_en;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic b;
    logic fs;
    logic fe;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  typedef struct {
    int         d;
    logic [7:0] data;
    logic [7:0] seq;   // seq[i] = i-th bit expected on sout
  } vec_t;

  vec_t vecs [7];

  piso_serializer #(.N(8), .LSB_FIRST(1'b1), .GAP(0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .load_data(ld[0]), .load_valid(lv[0]),
    .load_ready(lr[0]), .sout(so[0]), .sout_valid(sv[0]),
    .frame_start(fs[0]), .frame_end(fe[0]), .busy(bz[0]));

  piso_serializer #(.N(8), .LSB_FIRST(1'b0), .GAP(0)) u_msb (
    .clk(clk), .rst_n(rst_n), .load_data(ld[1]), .load_valid(lv[1]),
    .load_ready(lr[1]), .sout(so[1]), .sout_valid(sv[1]),
    .frame_start(fs[1]), .frame_end(fe[1]), .busy(bz[1]));

  piso_serializer #(.N(8), .LSB_FIRST(1'b1), .GAP(3)) u_gap (
    .clk(clk), .rst_n(rst_n), .load_data(ld[2]), .load_valid(lv[2]),
    .load_ready(lr[2]), .sout(so[2]), .sout_valid(sv[2]),
    .frame_start(fs[2]), .frame_end(fe[2]), .busy(bz[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int d);
    case (d)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t qpop(input int d);
    case (d)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic push_word(input int d, input logic [7:0] seq, input int nbits);
    exp_t e;
    for (int i = 0; i < nbits; i++) begin
      e.b  = seq[i];
      e.fs = (i == 0);
      e.fe = (i == 7);
      case (d)
        0: q0.push_back(e);
        1: q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
  endtask

  // Scoreboard: each sout_valid cycle consumes one expected bit.
  task automatic mon_one(input int d);
    exp_t e;
    if (sv[d]) begin
      if (qsize(d) == 0) begin
        chk($sformatf("d%0d extra_bit", d), 32'(sv[d]), 32'd0);
      end else begin
        e = qpop(d);
        chk($sformatf("d%0d sout", d), 32'(so[d]), 32'(e.b));
        chk($sformatf("d%0d frame_start", d), 32'(fs[d]), 32'(e.fs));
        chk($sformatf("d%0d frame_end", d), 32'(fe[d]), 32'(e.fe));
      end
    end else begin
      chk($sformatf("d%0d idle_sout", d), 32'(so[d]), 32'd0);
      chk($sformatf("d%0d idle_fs", d), 32'(fs[d]), 32'd0);
      chk($sformatf("d%0d idle_fe", d), 32'(fe[d]), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 3; d++) mon_one(d);
    end
  end

  // Single isolated word with per-cycle busy/load_ready expectations.
  task automatic run_vec(input int d, input logic [7:0] data, input logic [7:0] seq);
    int g;
    g = (d == 2) ? 3 : 0;
    ld[d] = data;
    lv[d] = 1'b1;
    push_word(d, seq, 8);
    @(negedge clk);
    chk($sformatf("d%0d ready_before_load", d), 32'(lr[d]), 32'd1);
    @(posedge clk); #1;
    lv[d] = 1'b0;
    for (int c = 1; c <= 9 + g; c++) begin
      @(negedge clk);
      chk($sformatf("d%0d busy c%0d", d, c), 32'(bz[d]), 32'(c <= 8 + g));
      chk($sformatf("d%0d ready c%0d", d, c), 32'(lr[d]),
          32'((g == 0 && c == 8) || (g > 0 && c == 8 + g) || (c == 9 + g)));
      chk($sformatf("d%0d valid c%0d", d, c), 32'(sv[d]), 32'(c <= 8));
      @(posedge clk); #1;
    end
    chk($sformatf("d%0d bits_left", d), 32'(qsize(d)), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{0, 8'hB4, 8'hB4};
    vecs[1] = '{1, 8'hB4, 8'h2D};
    vecs[2] = '{0, 8'h01, 8'h01};
    vecs[3] = '{1, 8'h01, 8'h80};
    vecs[4] = '{0, 8'hC1, 8'hC1};
    vecs[5] = '{1, 8'hC1, 8'h83};
    vecs[6] = '{2, 8'hB4, 8'hB4};

    mon_en = 1'b0;
    rst_n  = 1'b0;
    for (int d = 0; d < 3; d++) begin
      ld[d] = 8'hAA;
      lv[d] = 1'b1;
    end

    // Reset held with load_valid high: nothing may be accepted.
    @(posedge clk); #1;
    mon_en = 1'b1;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("d%0d rst_ready", d), 32'(lr[d]), 32'd0);
        chk($sformatf("d%0d rst_valid", d), 32'(sv[d]), 32'd0);
        chk($sformatf("d%0d rst_busy", d), 32'(bz[d]), 32'd0);
        chk($sformatf("d%0d rst_sout", d), 32'(so[d]), 32'd0);
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    for (int d = 0; d < 3; d++) lv[d] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("d%0d release_ready", d), 32'(lr[d]), 32'd1);
      chk($sformatf("d%0d release_busy", d), 32'(bz[d]), 32'd0);
    end
    @(posedge clk); #1;

    // Table of isolated words.
    for (int i = 0; i < 7; i++) run_vec(vecs[i].d, vecs[i].data, vecs[i].seq);

    // Back-to-back, GAP 0: 16 contiguous valid cycles.
    ld[0] = 8'h0F; lv[0] = 1'b1; push_word(0, 8'h0F, 8);
    @(negedge clk);
    chk("b2b ready_before_load", 32'(lr[0]), 32'd1);
    @(posedge clk); #1;
    ld[0] = 8'hF0; push_word(0, 8'hF0, 8);
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      chk($sformatf("b2b valid c%0d", c), 32'(sv[0]), 32'(c <= 16));
      chk($sformatf("b2b ready c%0d", c), 32'(lr[0]), 32'(c == 8 || c == 16 || c == 17));
      @(posedge clk); #1;
      if (c == 8) lv[0] = 1'b0;
    end
    chk("b2b bits_left", 32'(qsize(0)), 32'd0);

    // GAP 3 with two queued words.
    ld[2] = 8'h3C; lv[2] = 1'b1; push_word(2, 8'h3C, 8);
    @(negedge clk);
    chk("gap ready_before_load", 32'(lr[2]), 32'd1);
    @(posedge clk); #1;
    ld[2] = 8'hA5; push_word(2, 8'hA5, 8);
    for (int c = 1; c <= 23; c++) begin
      @(negedge clk);
      chk($sformatf("gap valid c%0d", c), 32'(sv[2]), 32'(c <= 8 || (c >= 12 && c <= 19)));
      chk($sformatf("gap ready c%0d", c), 32'(lr[2]), 32'(c == 11 || c == 22 || c == 23));
      chk($sformatf("gap busy c%0d", c), 32'(bz[2]), 32'(c <= 22));
      @(posedge clk); #1;
      if (c == 11) lv[2] = 1'b0;
    end
    chk("gap bits_left", 32'(qsize(2)), 32'd0);

    // Mid-word reset: only bits 1..4 may appear, no frame_end.
    ld[0] = 8'hFF; lv[0] = 1'b1; push_word(0, 8'hFF, 4);
    @(negedge clk);
    chk("mrst ready_before_load", 32'(lr[0]), 32'd1);
    @(posedge clk); #1;
    lv[0] = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk($sformatf("mrst busy c%0d", c), 32'(bz[0]), 32'd1);
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst valid_bit4", 32'(sv[0]), 32'd1);
    chk("mrst ready_in_reset", 32'(lr[0]), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst valid_after", 32'(sv[0]), 32'd0);
    chk("mrst busy_after", 32'(bz[0]), 32'd0);
    chk("mrst ready_after", 32'(lr[0]), 32'd1);
    chk("mrst bits_left", 32'(qsize(0)), 32'd0);
    @(posedge clk); #1;
    run_vec(0, 8'h01, 8'h01);

    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) chk($sformatf("d%0d final_bits_left", d), 32'(qsize(d)), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
